// File: rtl/perf_latency_mon_if.sv
// Bus bundle for perf_latency_mon: strobes, clear, read request and monitor outputs.
// The master modport is the side that drives strobes and reads; the slave modport is the monitor.
interface perf_latency_mon_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] i_req;
  logic [NUM_CH-1:0] i_done;
  logic              i_clear;
  logic              i_rd_en;
  logic [CH_W-1:0]   i_rd_ch;
  logic [2:0]        i_rd_sel;
  logic [CNT_W-1:0]  o_rd_data;
  logic              o_rd_valid;
  logic [NUM_CH-1:0] o_busy;
  logic [NUM_CH-1:0] o_overflow;

  modport master (
    output i_req, i_done, i_clear, i_rd_en, i_rd_ch, i_rd_sel,
    input  o_rd_data, o_rd_valid, o_busy, o_overflow
  );

  modport slave (
    input  i_req, i_done, i_clear, i_rd_en, i_rd_ch, i_rd_sel,
    output o_rd_data, o_rd_valid, o_busy, o_overflow
  );
endinterface

// File: rtl/perf_latency_mon.sv
// Multi-channel transaction latency monitor: last/min/max/count/overflow per channel, registered read port.
// Defining PERF_LAT_MON_SUM_EN adds a saturating per-channel latency sum (sel 5, status bit3).
module perf_latency_mon #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TXN_W  = 16
) (
  input logic               clk,
  input logic               reset,
  perf_latency_mon_if.slave bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  last_q  [NUM_CH];
  logic [CNT_W-1:0]  last_d  [NUM_CH];
  logic [CNT_W-1:0]  min_q   [NUM_CH];
  logic [CNT_W-1:0]  min_d   [NUM_CH];
  logic [CNT_W-1:0]  max_q   [NUM_CH];
  logic [CNT_W-1:0]  max_d   [NUM_CH];
  logic [TXN_W-1:0]  txn_q   [NUM_CH];
  logic [TXN_W-1:0]  txn_d   [NUM_CH];
  logic [CNT_W-1:0]  lat     [NUM_CH];
  logic [NUM_CH-1:0] rec;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] spur_q, spur_d;
  logic [NUM_CH-1:0] busy;
`ifdef PERF_LAT_MON_SUM_EN
  logic [CNT_W-1:0]  sum_q   [NUM_CH];
  logic [CNT_W-1:0]  sum_d   [NUM_CH];
  logic [NUM_CH-1:0] sovf_q, sovf_d;
`endif
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      busy[c] = (state_q[c] == S_BUSY);
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    spur_d = spur_q;
    rec    = '0;
`ifdef PERF_LAT_MON_SUM_EN
    sovf_d = sovf_q;
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      last_d[c]  = last_q[c];
      min_d[c]   = min_q[c];
      max_d[c]   = max_q[c];
      txn_d[c]   = txn_q[c];
      lat[c]     = '0;
`ifdef PERF_LAT_MON_SUM_EN
      sum_d[c]   = sum_q[c];
`endif
      unique case (state_q[c])
        S_IDLE: begin
          if (bus.i_req[c] && bus.i_done[c]) begin
            rec[c] = 1'b1;
          end else if (bus.i_req[c]) begin
            state_d[c] = S_BUSY;
            cnt_d[c]   = CNT_W'(1);
          end else if (bus.i_done[c]) begin
            spur_d[c] = 1'b1;
          end
        end
        S_BUSY: begin
          if (bus.i_done[c]) begin
            rec[c] = 1'b1;
            lat[c] = cnt_q[c];
            if (bus.i_req[c]) begin
              cnt_d[c] = CNT_W'(1);
            end else begin
              state_d[c] = S_IDLE;
              cnt_d[c]   = '0;
            end
          end else if (cnt_q[c] != '1) begin
            cnt_d[c] = cnt_q[c] + 1'b1;
            if (cnt_d[c] == '1) ovf_d[c] = 1'b1;
          end
        end
        default: state_d[c] = S_IDLE;
      endcase

      if (rec[c]) begin
        last_d[c] = lat[c];
        if (lat[c] < min_q[c]) min_d[c] = lat[c];
        if (lat[c] > max_q[c]) max_d[c] = lat[c];
        if (txn_q[c] != '1) txn_d[c] = txn_q[c] + 1'b1;
`ifdef PERF_LAT_MON_SUM_EN
        // ~sum is the headroom left before the accumulator pins at all-ones
        if (lat[c] >= ~sum_q[c]) begin
          sum_d[c]  = '1;
          sovf_d[c] = 1'b1;
        end else begin
          sum_d[c] = sum_q[c] + lat[c];
        end
`endif
      end
    end

    // Read mux samples pre-update state so a same-edge record is not visible
    rd_valid_d = bus.i_rd_en;
    rd_data_d  = rd_data_q;
    if (bus.i_rd_en) begin
      rd_data_d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (CH_W'(c) == bus.i_rd_ch) begin
          case (bus.i_rd_sel)
            3'd0: rd_data_d = last_q[c];
            3'd1: rd_data_d = min_q[c];
            3'd2: rd_data_d = max_q[c];
            3'd3: rd_data_d = CNT_W'(txn_q[c]);
            3'd4: begin
              rd_data_d[0] = busy[c];
              rd_data_d[1] = ovf_q[c];
              rd_data_d[2] = spur_q[c];
`ifdef PERF_LAT_MON_SUM_EN
              rd_data_d[3] = sovf_q[c];
`endif
            end
`ifdef PERF_LAT_MON_SUM_EN
            3'd5: rd_data_d = sum_q[c];
`endif
            default: rd_data_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.i_clear) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
        last_q[c]  <= '0;
        min_q[c]   <= '1;
        max_q[c]   <= '0;
        txn_q[c]   <= '0;
`ifdef PERF_LAT_MON_SUM_EN
        sum_q[c]   <= '0;
`endif
      end
      ovf_q      <= '0;
      spur_q     <= '0;
`ifdef PERF_LAT_MON_SUM_EN
      sovf_q     <= '0;
`endif
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        last_q[c]  <= last_d[c];
        min_q[c]   <= min_d[c];
        max_q[c]   <= max_d[c];
        txn_q[c]   <= txn_d[c];
`ifdef PERF_LAT_MON_SUM_EN
        sum_q[c]   <= sum_d[c];
`endif
      end
      ovf_q      <= ovf_d;
      spur_q     <= spur_d;
`ifdef PERF_LAT_MON_SUM_EN
      sovf_q     <= sovf_d;
`endif
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.o_busy     = busy;
  assign bus.o_overflow = ovf_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
endmodule

// File: tb/tb_perf_latency_mon.sv
// Scoreboard bench for perf_latency_mon: a 2-channel 32-bit instance and a 1-channel 4-bit instance.
// Expected read data is queued when a read is issued and checked when o_rd_valid returns.
module tb_perf_latency_mon;
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic en_seen_a = 1'b0;
  logic en_seen_b = 1'b0;

`ifdef PERF_LAT_MON_SUM_EN
  localparam logic [31:0] SUM_CH1 = 32'd18;
  localparam logic [31:0] SUM_COL = 32'd8;
`else
  localparam logic [31:0] SUM_CH1 = 32'd0;
  localparam logic [31:0] SUM_COL = 32'd0;
`endif

  always #5 clk = ~clk;

  perf_latency_mon_if #(.NUM_CH(2), .CNT_W(32)) bus_a ();
  perf_latency_mon_if #(.NUM_CH(1), .CNT_W(4))  bus_b ();

  perf_latency_mon #(.NUM_CH(2), .CNT_W(32), .TXN_W(16)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  perf_latency_mon #(.NUM_CH(1), .CNT_W(4), .TXN_W(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd_start_a(input int ch, input int sel, input logic [31:0] exp, input string tag);
    q_a.push_back('{tag, exp});
    bus_a.i_rd_en  = 1'b1;
    bus_a.i_rd_ch  = 1'(ch);
    bus_a.i_rd_sel = 3'(sel);
  endtask

  task automatic rd_a(input int ch, input int sel, input logic [31:0] exp, input string tag);
    rd_start_a(ch, sel, exp, tag);
    tick();
    bus_a.i_rd_en = 1'b0;
  endtask

  task automatic rd_b(input int ch, input int sel, input logic [31:0] exp, input string tag);
    q_b.push_back('{tag, exp});
    bus_b.i_rd_en  = 1'b1;
    bus_b.i_rd_ch  = 1'(ch);
    bus_b.i_rd_sel = 3'(sel);
    tick();
    bus_b.i_rd_en = 1'b0;
  endtask

  task automatic clear_a();
    bus_a.i_clear = 1'b1;
    tick();
    bus_a.i_clear = 1'b0;
  endtask

  always @(posedge clk) begin
    en_seen_a <= bus_a.i_rd_en;
    en_seen_b <= bus_b.i_rd_en;
  end

  always @(negedge clk) begin
    exp_t e;
    if (en_seen_a || bus_a.o_rd_valid === 1'b1) check("rd_valid_a", 32'(bus_a.o_rd_valid), 32'(en_seen_a));
    if (bus_a.o_rd_valid === 1'b1) begin
      if (q_a.size() == 0) check("rd_spare_a", 32'(bus_a.o_rd_valid), 32'd0);
      else begin
        e = q_a.pop_front();
        check(e.tag, bus_a.o_rd_data, e.val);
      end
    end
    if (en_seen_b || bus_b.o_rd_valid === 1'b1) check("rd_valid_b", 32'(bus_b.o_rd_valid), 32'(en_seen_b));
    if (bus_b.o_rd_valid === 1'b1) begin
      if (q_b.size() == 0) check("rd_spare_b", 32'(bus_b.o_rd_valid), 32'd0);
      else begin
        e = q_b.pop_front();
        check(e.tag, 32'(bus_b.o_rd_data), e.val);
      end
    end
  end

  initial begin
    logic [1:0] r, d;
    bus_a.i_req = '0; bus_a.i_done = '0; bus_a.i_clear = 1'b0;
    bus_a.i_rd_en = 1'b0; bus_a.i_rd_ch = '0; bus_a.i_rd_sel = '0;
    bus_b.i_req = '0; bus_b.i_done = '0; bus_b.i_clear = 1'b0;
    bus_b.i_rd_en = 1'b0; bus_b.i_rd_ch = '0; bus_b.i_rd_sel = '0;
    repeat (2) tick();
    reset = 1'b0;

    check("rst_busy", 32'(bus_a.o_busy), 32'd0);
    check("rst_ovf", 32'(bus_a.o_overflow), 32'd0);
    rd_a(0, 0, 32'd0, "rst_last");
    rd_a(0, 1, 32'hFFFF_FFFF, "rst_min");
    rd_a(0, 2, 32'd0, "rst_max");
    rd_a(0, 3, 32'd0, "rst_txn");
    rd_a(0, 4, 32'd0, "rst_status");
    rd_a(0, 5, 32'd0, "rst_sum");
    tick();

    // Single transaction of latency 7 on ch0
    bus_a.i_req = 2'b01; tick(); bus_a.i_req = '0;
    for (int k = 1; k <= 6; k++) begin
      check("single_busy", 32'(bus_a.o_busy[0]), 32'd1);
      tick();
    end
    check("single_busy_t7", 32'(bus_a.o_busy[0]), 32'd1);
    bus_a.i_done = 2'b01; tick(); bus_a.i_done = '0;
    check("single_idle", 32'(bus_a.o_busy[0]), 32'd0);
    rd_a(0, 0, 32'd7, "single_last");
    rd_a(0, 1, 32'd7, "single_min");
    rd_a(0, 2, 32'd7, "single_max");
    rd_a(0, 3, 32'd1, "single_txn");

    // ch1: 3, then 10 and 5 joined back-to-back; ch0: concurrent latency 4
    clear_a();
    for (int k = 0; k < 22; k++) begin
      r = '0; d = '0;
      if (k == 1) r[0] = 1'b1;
      if (k == 5) d[0] = 1'b1;
      if (k == 0 || k == 5 || k == 15) r[1] = 1'b1;
      if (k == 3 || k == 15 || k == 20) d[1] = 1'b1;
      if (k == 10 || k == 16) check("mixed_busy", 32'(bus_a.o_busy), 32'b10);
      bus_a.i_req = r; bus_a.i_done = d;
      tick();
    end
    bus_a.i_req = '0; bus_a.i_done = '0;
    check("mixed_idle", 32'(bus_a.o_busy), 32'd0);
    rd_a(1, 0, 32'd5, "mixed1_last");
    rd_a(1, 1, 32'd3, "mixed1_min");
    rd_a(1, 2, 32'd10, "mixed1_max");
    rd_a(1, 3, 32'd3, "mixed1_txn");
    rd_a(1, 5, SUM_CH1, "mixed1_sum");
    rd_a(0, 0, 32'd4, "mixed0_last");
    rd_a(0, 1, 32'd4, "mixed0_min");
    rd_a(0, 2, 32'd4, "mixed0_max");
    rd_a(0, 3, 32'd1, "mixed0_txn");

    // Zero latency, then a spurious done
    clear_a();
    bus_a.i_req = 2'b01; bus_a.i_done = 2'b01; tick();
    bus_a.i_req = '0; bus_a.i_done = '0;
    check("zero_busy", 32'(bus_a.o_busy), 32'd0);
    rd_a(0, 0, 32'd0, "zero_last");
    rd_a(0, 1, 32'd0, "zero_min");
    rd_a(0, 3, 32'd1, "zero_txn");
    bus_a.i_done = 2'b01; tick(); bus_a.i_done = '0;
    rd_a(0, 4, 32'h4, "spur_status");
    rd_a(0, 3, 32'd1, "spur_txn");
    rd_a(1, 4, 32'h0, "spur_other_ch");

    // Read on the same edge as a record of 6, after a prior 2
    clear_a();
    bus_a.i_req = 2'b01; tick(); bus_a.i_req = '0;
    tick();
    bus_a.i_done = 2'b01; tick(); bus_a.i_done = '0;
    bus_a.i_req = 2'b01; tick(); bus_a.i_req = '0;
    repeat (5) tick();
    bus_a.i_done = 2'b01;
    rd_start_a(0, 0, 32'd2, "coll_pre");
    tick();
    bus_a.i_done = '0; bus_a.i_rd_en = 1'b0;
    rd_a(0, 0, 32'd6, "coll_post");
    rd_a(0, 1, 32'd2, "coll_min");
    rd_a(0, 2, 32'd6, "coll_max");
    rd_a(0, 5, SUM_COL, "coll_sum");
    rd_a(0, 6, 32'd0, "sel6_zero");

    // 4-bit counter saturation
    bus_b.i_req = 1'b1; tick(); bus_b.i_req = '0;
    for (int j = 0; j < 20; j++) begin
      if (j == 13) check("ovf_pre", 32'(bus_b.o_overflow), 32'd0);
      if (j == 14) check("ovf_set", 32'(bus_b.o_overflow), 32'd1);
      tick();
    end
    bus_b.i_done = 1'b1; tick(); bus_b.i_done = '0;
    check("ovf_busy", 32'(bus_b.o_busy), 32'd0);
    rd_b(0, 0, 32'd15, "ovf_last");
    rd_b(0, 2, 32'd15, "ovf_max");
    rd_b(0, 3, 32'd1, "ovf_txn");
    rd_b(0, 4, 32'h2, "ovf_status");
    repeat (5) tick();
    check("ovf_sticky", 32'(bus_b.o_overflow), 32'd1);

    // Clear mid-transaction aborts without a record
    bus_b.i_req = 1'b1; tick(); bus_b.i_req = '0;
    repeat (3) tick();
    check("clr_busy_pre", 32'(bus_b.o_busy), 32'd1);
    bus_b.i_clear = 1'b1; tick(); bus_b.i_clear = 1'b0;
    check("clr_busy", 32'(bus_b.o_busy), 32'd0);
    check("clr_ovf", 32'(bus_b.o_overflow), 32'd0);
    rd_b(0, 0, 32'd0, "clr_last");
    rd_b(0, 1, 32'hF, "clr_min");
    rd_b(0, 2, 32'd0, "clr_max");
    rd_b(0, 3, 32'd0, "clr_txn");
    rd_b(0, 4, 32'h0, "clr_status");
    bus_b.i_done = 1'b1; tick(); bus_b.i_done = '0;
    rd_b(0, 4, 32'h4, "clr_spur_status");
    rd_b(0, 3, 32'd0, "clr_spur_txn");
    rd_b(1, 0, 32'd0, "oor_ch");

    repeat (3) tick();
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
